// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS pipeline types, widths and ALUOp encodings
package mips_pkg;

   localparam int REG_W  = 5;
   localparam int XLEN   = 32;
   localparam int CTRL_W = 9;

   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'b00,
      ALUOP_SUB   = 2'b01,
      ALUOP_FUNCT = 2'b10
   } alu_op_e;

   // Field order fixes the bit layout: reg_write is bit 8, alu_op is bits 1:0.
   typedef struct packed {
      logic       reg_write;
      logic       mem_read;
      logic       mem_write;
      logic       mem_to_reg;
      logic       alu_src;
      logic       reg_dst;
      logic       branch;
      logic [1:0] alu_op;
   } ctrl_t;

endpackage

// File: rtl/id_ex_stage_if.sv
// rtl/id_ex_stage_if.sv - ID-to-EX bundle: decoded fields in, EX state and stall out
interface id_ex_stage_if
   import mips_pkg::*;
#(
   parameter int CNT_W = 16
);
   logic             id_valid;
   logic [REG_W-1:0] id_rs;
   logic [REG_W-1:0] id_rt;
   logic [REG_W-1:0] id_rd;
   logic [XLEN-1:0]  id_imm;
   ctrl_t            id_ctrl;
   logic [XLEN-1:0]  regA;
   logic [XLEN-1:0]  regB;
   logic             flush;
   logic             ex_hold;

   logic             stall_out;
   logic             ex_valid;
   logic [REG_W-1:0] ex_rs;
   logic [REG_W-1:0] ex_rt;
   logic [REG_W-1:0] ex_rd;
   logic [XLEN-1:0]  ex_imm;
   logic [XLEN-1:0]  ex_a;
   logic [XLEN-1:0]  ex_b;
   ctrl_t            ex_ctrl;
   logic [CNT_W-1:0] bubble_cnt;

   modport master (
      output id_valid, id_rs, id_rt, id_rd, id_imm, id_ctrl, regA, regB, flush, ex_hold,
      input  stall_out, ex_valid, ex_rs, ex_rt, ex_rd, ex_imm, ex_a, ex_b, ex_ctrl, bubble_cnt
   );

   modport slave (
      input  id_valid, id_rs, id_rt, id_rd, id_imm, id_ctrl, regA, regB, flush, ex_hold,
      output stall_out, ex_valid, ex_rs, ex_rt, ex_rd, ex_imm, ex_a, ex_b, ex_ctrl, bubble_cnt
   );

endinterface

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - load-use hazard between the load in EX and the instruction in ID
module hazard_detect
   import mips_pkg::*;
(
   input  logic             ex_valid_i,
   input  logic             ex_mem_read_i,
   input  logic [REG_W-1:0] ex_rt_i,
   input  logic             id_valid_i,
   input  logic [REG_W-1:0] id_rs_i,
   input  logic [REG_W-1:0] id_rt_i,
   output logic             lu_o
);

   // rt is compared for every opcode; a false stall costs one cycle, a miss costs correctness.
   assign lu_o = ex_valid_i & ex_mem_read_i & (ex_rt_i != '0) & id_valid_i &
                 ((ex_rt_i == id_rs_i) | (ex_rt_i == id_rt_i));

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use stall, flush, hold and bubble count
module id_ex_stage
   import mips_pkg::*;
#(
   parameter int CNT_W = 16
)(
   input  logic         clk,
   input  logic         rst,
   id_ex_stage_if.slave bus
);

   logic             valid_q, valid_d;
   logic [REG_W-1:0] rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
   logic [XLEN-1:0]  imm_q, imm_d, a_q, a_d, b_q, b_d;
   ctrl_t            ctrl_q, ctrl_d;
   logic [CNT_W-1:0] bubble_q, bubble_d;
   logic             lu;

   hazard_detect u_hazard (
      .ex_valid_i    (valid_q),
      .ex_mem_read_i (ctrl_q.mem_read),
      .ex_rt_i       (rt_q),
      .id_valid_i    (bus.id_valid),
      .id_rs_i       (bus.id_rs),
      .id_rt_i       (bus.id_rt),
      .lu_o          (lu)
   );

   always_comb begin
      valid_d  = valid_q;
      rs_d     = rs_q;
      rt_d     = rt_q;
      rd_d     = rd_q;
      imm_d    = imm_q;
      a_d      = a_q;
      b_d      = b_q;
      ctrl_d   = ctrl_q;
      bubble_d = bubble_q;
      if (bus.flush) begin
         valid_d = 1'b0;
         rs_d    = '0;
         rt_d    = '0;
         rd_d    = '0;
         imm_d   = '0;
         a_d     = '0;
         b_d     = '0;
         ctrl_d  = '0;
      end else if (bus.ex_hold) begin
         valid_d = valid_q;
      end else if (lu) begin
         valid_d = 1'b0;
         ctrl_d  = '0;
         if (bubble_q != '1) begin
            bubble_d = bubble_q + CNT_W'(1);
         end
      end else begin
         valid_d = bus.id_valid;
         rs_d    = bus.id_rs;
         rt_d    = bus.id_rt;
         rd_d    = bus.id_rd;
         imm_d   = bus.id_imm;
         a_d     = bus.regA;
         b_d     = bus.regB;
         ctrl_d  = bus.id_valid ? bus.id_ctrl : '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q  <= 1'b0;
         rs_q     <= '0;
         rt_q     <= '0;
         rd_q     <= '0;
         imm_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         ctrl_q   <= '0;
         bubble_q <= '0;
      end else begin
         valid_q  <= valid_d;
         rs_q     <= rs_d;
         rt_q     <= rt_d;
         rd_q     <= rd_d;
         imm_q    <= imm_d;
         a_q      <= a_d;
         b_q      <= b_d;
         ctrl_q   <= ctrl_d;
         bubble_q <= bubble_d;
      end
   end

   assign bus.stall_out  = ~bus.flush & (bus.ex_hold | lu);
   assign bus.ex_valid   = valid_q;
   assign bus.ex_rs      = rs_q;
   assign bus.ex_rt      = rt_q;
   assign bus.ex_rd      = rd_q;
   assign bus.ex_imm     = imm_q;
   assign bus.ex_a       = a_q;
   assign bus.ex_b       = b_q;
   assign bus.ex_ctrl    = ctrl_q;
   assign bus.bubble_cnt = bubble_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - scoreboard bench for id_ex_stage with directed vectors
module tb_id_ex_stage;
   import mips_pkg::*;

   localparam int CNT_W = 4;
   localparam logic [8:0] C_ALU = 9'h10A;
   localparam logic [8:0] C_LW  = 9'h1B0;

   typedef enum {M_CAP, M_HOLD, M_BUB, M_CLR} mode_e;

   typedef struct packed {
      logic             valid;
      logic [4:0]       rs;
      logic [4:0]       rt;
      logic [4:0]       rd;
      logic [31:0]      imm;
      logic [31:0]      a;
      logic [31:0]      b;
      logic [8:0]       ctrl;
      logic [CNT_W-1:0] cnt;
   } ex_t;

   typedef struct {
      int  stl;
      ex_t st;
   } item_t;

   logic  clk = 1'b0;
   logic  rst = 1'b0;
   int    n_checks = 0;
   int    n_fail = 0;
   item_t sb[$];
   ex_t   exp_s = '0;

   always #5 clk = ~clk;

   id_ex_stage_if #(.CNT_W(CNT_W)) bus ();

   id_ex_stage #(.CNT_W(CNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [31:0] imm, input logic [8:0] ctrl,
                        input logic [31:0] a, input logic [31:0] b, input logic fl,
                        input logic hd, input logic r, input mode_e m, input int stl,
                        input int cnt);
      item_t it;
      @(negedge clk);
      bus.id_valid = v;
      bus.id_rs    = rs;
      bus.id_rt    = rt;
      bus.id_rd    = rd;
      bus.id_imm   = imm;
      bus.id_ctrl  = ctrl_t'(ctrl);
      bus.regA     = a;
      bus.regB     = b;
      bus.flush    = fl;
      bus.ex_hold  = hd;
      rst          = r;
      case (m)
         M_CAP: begin
            exp_s.valid = v;
            exp_s.rs    = rs;
            exp_s.rt    = rt;
            exp_s.rd    = rd;
            exp_s.imm   = imm;
            exp_s.a     = a;
            exp_s.b     = b;
            exp_s.ctrl  = v ? ctrl : 9'h000;
         end
         M_BUB: begin
            exp_s.valid = 1'b0;
            exp_s.ctrl  = 9'h000;
         end
         M_CLR:   exp_s = '0;
         default: exp_s = exp_s;
      endcase
      exp_s.cnt = CNT_W'(cnt);
      it.stl = stl;
      it.st  = exp_s;
      sb.push_back(it);
   endtask

   // Monitor: stall_out is checked between negedge and posedge, EX state just after posedge.
   initial begin
      item_t it;
      ex_t   act;
      forever begin
         @(negedge clk);
         #2;
         if (sb.size() != 0) begin
            it = sb.pop_front();
            if (it.stl >= 0) begin
               n_checks++;
               if (bus.stall_out !== it.stl[0]) begin
                  n_fail++;
                  $display("FAIL stall_out: got %b expected %0d", bus.stall_out, it.stl);
               end
            end
            @(posedge clk);
            #2;
            act = '{valid: bus.ex_valid, rs: bus.ex_rs, rt: bus.ex_rt, rd: bus.ex_rd,
                    imm: bus.ex_imm, a: bus.ex_a, b: bus.ex_b, ctrl: bus.ex_ctrl,
                    cnt: bus.bubble_cnt};
            n_checks++;
            if (act !== it.st) begin
               n_fail++;
               $display("FAIL ex_state: got v=%b rs=%0d rt=%0d rd=%0d imm=%h a=%h b=%h ctrl=%h cnt=%0d expected v=%b rs=%0d rt=%0d rd=%0d imm=%h a=%h b=%h ctrl=%h cnt=%0d",
                        act.valid, act.rs, act.rt, act.rd, act.imm, act.a, act.b, act.ctrl, act.cnt,
                        it.st.valid, it.st.rs, it.st.rt, it.st.rd, it.st.imm, it.st.a, it.st.b,
                        it.st.ctrl, it.st.cnt);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      // reset: first cycle stall is unknown, second must be 0
      drive(0, 0, 0, 0, 0, 9'h0, 0, 0, 0, 0, 1, M_CLR, -1, 0);
      drive(0, 0, 0, 0, 0, 9'h0, 0, 0, 0, 0, 1, M_CLR, 0, 0);
      // plain ALU op
      drive(1, 2, 3, 5, 0, C_ALU, 25, 40, 0, 0, 0, M_CAP, 0, 0);
      // lw $4, then a consumer of $4 stalls one cycle and re-enters with fresh operands
      drive(1, 1, 4, 0, 8, C_LW, 100, 7, 0, 0, 0, M_CAP, 0, 0);
      drive(1, 4, 6, 7, 0, C_ALU, 11, 12, 0, 0, 0, M_BUB, 1, 1);
      drive(1, 4, 6, 7, 0, C_ALU, 55, 12, 0, 0, 0, M_CAP, 0, 1);
      // load into $0 never stalls
      drive(1, 1, 0, 0, 4, C_LW, 3, 0, 0, 0, 0, M_CAP, 0, 1);
      drive(1, 0, 0, 8, 0, C_ALU, 0, 0, 0, 0, 0, M_CAP, 0, 1);
      // flush beats the load-use hazard
      drive(1, 1, 9, 0, 12, C_LW, 200, 0, 0, 0, 0, M_CAP, 0, 1);
      drive(1, 1, 9, 10, 0, C_ALU, 66, 77, 1, 0, 0, M_CLR, 0, 1);
      // hold for three cycles, including a pending hazard, then release
      drive(1, 1, 9, 0, 16, C_LW, 300, 1, 0, 0, 0, M_CAP, 0, 1);
      drive(1, 9, 3, 11, 1, C_ALU, 1, 2, 0, 1, 0, M_HOLD, 1, 1);
      drive(1, 2, 9, 12, 2, C_ALU, 3, 4, 0, 1, 0, M_HOLD, 1, 1);
      drive(1, 3, 4, 13, 3, C_ALU, 5, 6, 0, 1, 0, M_HOLD, 1, 1);
      drive(1, 2, 3, 14, 4, C_ALU, 7, 8, 0, 0, 0, M_CAP, 0, 1);
      // invalid ID instruction gates its control bits
      drive(0, 4, 5, 6, 9, C_ALU, 9, 9, 0, 0, 0, M_CAP, 0, 1);
      // reset in the middle of a load-use stall
      drive(1, 1, 5, 0, 20, C_LW, 400, 0, 0, 0, 0, M_CAP, 0, 1);
      drive(1, 5, 2, 3, 0, C_ALU, 1, 1, 0, 0, 1, M_CLR, 1, 0);
      // 17 bubbles saturate a 4-bit counter at 15
      for (int k = 1; k <= 17; k++) begin
         drive(1, 1, 5, 0, 20, C_LW, 32'(k), 0, 0, 0, 0, M_CAP, 0, (k - 1 > 15) ? 15 : k - 1);
         if (k % 2 == 1)
            drive(1, 5, 2, 3, 0, C_ALU, 1, 1, 0, 0, 0, M_BUB, 1, (k > 15) ? 15 : k);
         else
            drive(1, 2, 5, 3, 0, C_ALU, 1, 1, 0, 0, 0, M_BUB, 1, (k > 15) ? 15 : k);
      end
      @(negedge clk);
      @(negedge clk);
      n_checks++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
